latency_meter: RTL and testbench

Measures the latency in clock cycles between a `start` pulse and the next `stop` pulse. It is the receiving end of the fixed-delay path: its primary use is to sit on the input and output of a `latency_long` instance (start = d, stop = q) and prove the configured delay in simulation and in-system debug. It also keeps per-run statistics for the debug register space.

---
 rtl/latency_meter.sv | 185 ++++++++++++++++++
 tb/tb_latency_meter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_meter.sv
// latency_meter: measures the number of clock cycles between a start pulse and
// the following stop pulse, with an optional abandon-on-timeout and running
// statistics (completed count, plus min/max when LATENCY_METER_MINMAX_EN is
// defined). Every output comes straight from a register.
module latency_meter #(
   parameter int CW      = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          clear,
   output logic          busy,
   output logic          valid,
   output logic [CW-1:0] lat,
   output logic          tmo,
   output logic [CW-1:0] n_meas
`ifdef LATENCY_METER_MINMAX_EN
   ,
   output logic [CW-1:0] min_lat,
   output logic [CW-1:0] max_lat
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   // The counter carries one bit more than the result so that it can hold
   // TIMEOUT+1 even when TIMEOUT is the largest CW-bit value. That value marks
   // the first cycle past the limit, where the measurement is abandoned.
   localparam logic [CW:0]   CNT_ZERO   = {(CW+1){1'b0}};
   localparam logic [CW:0]   CNT_ONE    = {{CW{1'b0}}, 1'b1};
   localparam logic [CW:0]   CNT_SAT    = {1'b0, {CW{1'b1}}};
   localparam logic [CW:0]   TMO_LIMIT  = (CW+1)'(TIMEOUT);
   localparam logic [CW:0]   CNT_EXPIRE = TMO_LIMIT + CNT_ONE;
   localparam bit            TMO_EN     = (TIMEOUT != 0);
   localparam logic [CW-1:0] ALL_ONES   = {CW{1'b1}};
   localparam logic [CW-1:0] ALL_ZEROS  = {CW{1'b0}};

   // Saturating increment for the completed-measurement counter.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == ALL_ONES) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t          state_r, state_s;
   logic [CW:0]     cnt_r, cnt_s;
   logic            busy_r, valid_r, tmo_r;
   logic [CW-1:0]   lat_r;
   logic [CW-1:0]   n_meas_r, n_meas_s;
   logic            done_s, tmo_s;
   logic [CW-1:0]   result_s;
`ifdef LATENCY_METER_MINMAX_EN
   logic [CW-1:0]   min_r, min_s;
   logic [CW-1:0]   max_r, max_s;
`endif

   // Measurement FSM: next state, counter, completion and timeout decisions.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      done_s   = 1'b0;
      tmo_s    = 1'b0;
      result_s = lat_r;
      case (state_r)
         IDLE: begin
            if (start && stop) begin
               done_s   = 1'b1;
               result_s = ALL_ZEROS;
            end else if (start) begin
               cnt_s   = CNT_ONE;
               state_s = MEAS;
            end else begin
               cnt_s = cnt_r;
            end
         end
         MEAS: begin
            if (TMO_EN && (cnt_r == CNT_EXPIRE)) begin
               // A full cycle past the limit without stop: give up. A stop
               // arriving this late is not reported as a result.
               tmo_s   = 1'b1;
               cnt_s   = CNT_ZERO;
               state_s = IDLE;
            end else if (stop) begin
               done_s   = 1'b1;
               result_s = cnt_r[CW-1:0];
               if (start) begin
                  cnt_s = CNT_ONE;
               end else begin
                  cnt_s   = CNT_ZERO;
                  state_s = IDLE;
               end
            end else if (TMO_EN || (cnt_r != CNT_SAT)) begin
               // With a timeout the count never passes TIMEOUT+1, so only the
               // unlimited case needs to saturate.
               cnt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Statistics: clear wins over a completion landing in the same cycle.
   always_comb begin
      n_meas_s = n_meas_r;
`ifdef LATENCY_METER_MINMAX_EN
      min_s = min_r;
      max_s = max_r;
`endif
      if (clear) begin
         n_meas_s = ALL_ZEROS;
`ifdef LATENCY_METER_MINMAX_EN
         min_s = ALL_ONES;
         max_s = ALL_ZEROS;
`endif
      end else if (done_s) begin
         n_meas_s = sat_inc(n_meas_r);
`ifdef LATENCY_METER_MINMAX_EN
         if (result_s < min_r) begin
            min_s = result_s;
         end else begin
            min_s = min_r;
         end
         if (result_s > max_r) begin
            max_s = result_s;
         end else begin
            max_s = max_r;
         end
`endif
      end else begin
         n_meas_s = n_meas_r;
      end
   end

   // State, counter and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
         tmo_r    <= 1'b0;
         lat_r    <= ALL_ZEROS;
         n_meas_r <= ALL_ZEROS;
`ifdef LATENCY_METER_MINMAX_EN
         min_r    <= ALL_ONES;
         max_r    <= ALL_ZEROS;
`endif
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         busy_r   <= (state_s == MEAS);
         valid_r  <= done_s;
         tmo_r    <= tmo_s;
         lat_r    <= result_s;
         n_meas_r <= n_meas_s;
`ifdef LATENCY_METER_MINMAX_EN
         min_r    <= min_s;
         max_r    <= max_s;
`endif
      end
   end

   assign busy   = busy_r;
   assign valid  = valid_r;
   assign tmo    = tmo_r;
   assign lat    = lat_r;
   assign n_meas = n_meas_r;
`ifdef LATENCY_METER_MINMAX_EN
   assign min_lat = min_r;
   assign max_lat = max_r;
`endif

endmodule

// File: tb/tb_latency_meter.sv
// Testbench for latency_meter. Instance u_a (CW=16, TIMEOUT=8) is tracked by a
// time-based reference model; instance u_b (CW=4, TIMEOUT=0) covers
// saturation, min/max (when LATENCY_METER_MINMAX_EN is defined) and reset.
module tb_latency_meter;

   localparam int T_A  = 8;
   localparam int MAXA = 65535;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, stop, clear;
   logic        busy, valid, tmo;
   logic [15:0] lat, n_meas;
   logic        b_rst_n, b_start, b_stop, b_clear;
   logic        b_busy, b_valid, b_tmo;
   logic [3:0]  b_lat, b_n;
`ifdef LATENCY_METER_MINMAX_EN
   logic [15:0] min_lat, max_lat;
   logic [3:0]  b_min, b_max;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   latency_meter #(.CW(16), .TIMEOUT(T_A)) u_a (
      .clock(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .busy(busy), .valid(valid), .lat(lat), .tmo(tmo), .n_meas(n_meas)
`ifdef LATENCY_METER_MINMAX_EN
      , .min_lat(min_lat), .max_lat(max_lat)
`endif
   );

   latency_meter #(.CW(4), .TIMEOUT(0)) u_b (
      .clock(clk), .rst_n(b_rst_n), .start(b_start), .stop(b_stop), .clear(b_clear),
      .busy(b_busy), .valid(b_valid), .lat(b_lat), .tmo(b_tmo), .n_meas(b_n)
`ifdef LATENCY_METER_MINMAX_EN
      , .min_lat(b_min), .max_lat(b_max)
`endif
   );

   // Reference model for u_a, expressed in elapsed edges since start.
   int cyc = 0;
   bit m_meas = 1'b0;
   int m_k = 0;
   bit m_valid = 1'b0, m_tmo = 1'b0, m_busy = 1'b0;
   int m_lat = 0, m_n = 0, m_min = MAXA, m_max = 0;

   task automatic model_step(input logic s, input logic p, input logic c, input logic r);
      bit done;
      int res;
      int el;
      done = 1'b0;
      res  = 0;
      if (!r) begin
         m_meas = 1'b0; m_valid = 1'b0; m_tmo = 1'b0; m_lat = 0;
         m_n = 0; m_min = MAXA; m_max = 0;
      end else begin
         m_valid = 1'b0;
         m_tmo   = 1'b0;
         if (!m_meas) begin
            if (s && p) begin
               done = 1'b1; res = 0;
            end else if (s) begin
               m_meas = 1'b1; m_k = cyc;
            end
         end else begin
            el = cyc - m_k;
            if (el > T_A) begin
               m_tmo = 1'b1; m_meas = 1'b0;
            end else if (p) begin
               done = 1'b1; res = el;
               if (s) m_k = cyc;
               else m_meas = 1'b0;
            end
         end
         if (done) begin
            m_valid = 1'b1; m_lat = res;
         end
         if (c) begin
            m_n = 0; m_min = MAXA; m_max = 0;
         end else if (done) begin
            if (m_n < MAXA) m_n++;
            if (res < m_min) m_min = res;
            if (res > m_max) m_max = res;
         end
      end
      m_busy = m_meas;
      cyc++;
   endtask

   task automatic drive(input logic s, input logic p, input logic c, input logic r);
      @(negedge clk);
      start = s; stop = p; clear = c; rst_n = r;
      @(posedge clk);
      model_step(s, p, c, r);
      #1;
   endtask

   task automatic drive_b(input logic s, input logic p, input logic c, input logic r);
      @(negedge clk);
      b_start = s; b_stop = p; b_clear = c; b_rst_n = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive_b(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
      n_checks++; if (tmo !== 1'b0) $display("FAIL reset_tmo: got %0b want 0", tmo); else n_pass++;
      n_checks++; if (lat !== 16'd0) $display("FAIL reset_lat: got %0d want 0", lat); else n_pass++;
      n_checks++; if (n_meas !== 16'd0) $display("FAIL reset_n_meas: got %0d want 0", n_meas); else n_pass++;
`ifdef LATENCY_METER_MINMAX_EN
      n_checks++; if (min_lat !== 16'hffff) $display("FAIL reset_min: got %0d want 65535", min_lat); else n_pass++;
      n_checks++; if (max_lat !== 16'd0) $display("FAIL reset_max: got %0d want 0", max_lat); else n_pass++;
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_zero();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++; if (valid !== 1'b1) $display("FAIL zero_valid: got %0b want 1", valid); else n_pass++;
      n_checks++; if (lat !== 16'd0) $display("FAIL zero_lat: got %0d want 0", lat); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy); else n_pass++;
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL stop_alone: got valid=%0b busy=%0b want 0 0", valid, busy); else n_pass++;
      n_checks++; if (n_meas !== 16'd1) $display("FAIL zero_n_meas: got %0d want 1", n_meas); else n_pass++;
   endtask

   // start = d, stop = q of a 5-cycle delay line fed with a single pulse.
   task automatic test_chain();
      logic [4:0] pipe;
      logic d;
      int nvalid, nbusy;
      pipe = 5'd0; nvalid = 0; nbusy = 0;
      for (int i = 0; i < 12; i++) begin
         d = (i == 0);
         drive(d, pipe[4], 1'b0, 1'b1);
         pipe = {pipe[3:0], d};
         if (valid === 1'b1) nvalid++;
         if (busy === 1'b1) nbusy++;
      end
      n_checks++; if (nvalid != 1) $display("FAIL chain_valid_count: got %0d want 1", nvalid); else n_pass++;
      n_checks++; if (lat !== 16'd5) $display("FAIL chain_lat: got %0d want 5", lat); else n_pass++;
      n_checks++; if (n_meas !== 16'd2) $display("FAIL chain_n_meas: got %0d want 2", n_meas); else n_pass++;
      n_checks++; if (nbusy != 5) $display("FAIL chain_busy_cycles: got %0d want 5", nbusy); else n_pass++;
   endtask

   task automatic test_timeout();
      int early, seen;
      early = 0; seen = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= 8; j++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1);
         if (tmo !== 1'b0 || busy !== 1'b1) early++;
      end
      n_checks++; if (early != 0) $display("FAIL tmo_early: got %0d bad cycles want 0", early); else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (tmo !== 1'b1) $display("FAIL tmo_pulse: got %0b want 1", tmo); else n_pass++;
      n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL tmo_busy_valid: got busy=%0b valid=%0b want 0 0", busy, valid); else n_pass++;
      n_checks++; if (lat !== 16'd5 || n_meas !== 16'd2) $display("FAIL tmo_unchanged: got lat=%0d n=%0d want 5 2", lat, n_meas); else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (tmo !== 1'b0) $display("FAIL tmo_one_cycle: got %0b want 0", tmo); else n_pass++;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= 10; j++) begin
         drive(1'b0, (j == 8), 1'b0, 1'b1);
         if (tmo === 1'b1) seen++;
         if (j == 8) begin
            n_checks++; if (valid !== 1'b1 || lat !== 16'd8) $display("FAIL tmo_boundary: got valid=%0b lat=%0d want 1 8", valid, lat); else n_pass++;
         end
      end
      n_checks++; if (seen != 0) $display("FAIL tmo_boundary_no_tmo: got %0d pulses want 0", seen); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lats[$];
      for (int i = 0; i < 12; i++) begin
         drive((i == 0 || i == 3 || i == 5), (i == 3 || i == 10), 1'b0, 1'b1);
         if (valid === 1'b1) lats.push_back(int'(lat));
      end
      n_checks++;
      if (lats.size() != 2) $display("FAIL b2b_count: got %0d want 2", lats.size());
      else if (lats[0] != 3 || lats[1] != 7) $display("FAIL b2b_lats: got %0d,%0d want 3,7", lats[0], lats[1]);
      else n_pass++;
   endtask

   task automatic test_clear();
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (valid !== 1'b1 || lat !== 16'd2) $display("FAIL clear_valid: got valid=%0b lat=%0d want 1 2", valid, lat); else n_pass++;
      n_checks++; if (n_meas !== 16'd0) $display("FAIL clear_n_meas: got %0d want 0", n_meas); else n_pass++;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++; if (busy !== 1'b1) $display("FAIL clear_no_abort: got busy=%0b want 1", busy); else n_pass++;
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++; if (valid !== 1'b1 || lat !== 16'd2 || n_meas !== 16'd1) $display("FAIL clear_after: got valid=%0b lat=%0d n=%0d want 1 2 1", valid, lat, n_meas); else n_pass++;
   endtask

   task automatic test_random();
      logic s, p, c;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 6) == 0);
         c = ($urandom_range(0, 29) == 0);
         drive(s, p, c, 1'b1);
         n_checks++; if (valid !== m_valid) $display("FAIL rnd_valid @%0d: got %0b want %0b", i, valid, m_valid); else n_pass++;
         n_checks++; if (tmo !== m_tmo) $display("FAIL rnd_tmo @%0d: got %0b want %0b", i, tmo, m_tmo); else n_pass++;
         n_checks++; if (busy !== m_busy) $display("FAIL rnd_busy @%0d: got %0b want %0b", i, busy, m_busy); else n_pass++;
         n_checks++; if (lat !== 16'(m_lat)) $display("FAIL rnd_lat @%0d: got %0d want %0d", i, lat, m_lat); else n_pass++;
         n_checks++; if (n_meas !== 16'(m_n)) $display("FAIL rnd_n_meas @%0d: got %0d want %0d", i, n_meas, m_n); else n_pass++;
`ifdef LATENCY_METER_MINMAX_EN
         n_checks++; if (min_lat !== 16'(m_min) || max_lat !== 16'(m_max)) $display("FAIL rnd_minmax @%0d: got %0d/%0d want %0d/%0d", i, min_lat, max_lat, m_min, m_max); else n_pass++;
`endif
      end
   endtask

   task automatic test_saturation();
      int seen;
      seen = 0;
      drive_b(1'b0, 1'b0, 1'b0, 1'b1);
      drive_b(1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= 20; j++) begin
         drive_b(1'b0, (j == 20), 1'b0, 1'b1);
         if (b_tmo === 1'b1) seen++;
      end
      n_checks++; if (b_valid !== 1'b1 || b_lat !== 4'd15) $display("FAIL sat_lat: got valid=%0b lat=%0d want 1 15", b_valid, b_lat); else n_pass++;
      n_checks++; if (seen != 0 || b_busy !== 1'b0) $display("FAIL sat_no_tmo: got tmo=%0d busy=%0b want 0 0", seen, b_busy); else n_pass++;
      n_checks++; if (b_n !== 4'd1) $display("FAIL sat_n: got %0d want 1", b_n); else n_pass++;
      drive_b(1'b1, 1'b0, 1'b0, 1'b1);
      drive_b(1'b0, 1'b0, 1'b0, 1'b1);
      drive_b(1'b0, 1'b0, 1'b0, 1'b1);
      drive_b(1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (b_valid !== 1'b1 || b_lat !== 4'd3 || b_n !== 4'd0) $display("FAIL sat_clear: got valid=%0b lat=%0d n=%0d want 1 3 0", b_valid, b_lat, b_n); else n_pass++;
   endtask

`ifdef LATENCY_METER_MINMAX_EN
   task automatic test_minmax();
      int lats[3];
      lats = '{4, 9, 2};
      drive_b(1'b0, 1'b0, 1'b1, 1'b1);
      for (int m = 0; m < 3; m++) begin
         drive_b(1'b1, 1'b0, 1'b0, 1'b1);
         for (int j = 1; j <= lats[m]; j++) drive_b(1'b0, (j == lats[m]), 1'b0, 1'b1);
      end
      n_checks++; if (b_min !== 4'd2 || b_max !== 4'd9) $display("FAIL minmax: got min=%0d max=%0d want 2 9", b_min, b_max); else n_pass++;
      n_checks++; if (b_n !== 4'd3) $display("FAIL minmax_n: got %0d want 3", b_n); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      int nvalid;
      nvalid = 0;
      drive_b(1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= 6; j++) drive_b(1'b0, (j == 6), 1'b0, 1'b1);
      n_checks++; if (b_lat !== 4'd6) $display("FAIL pre_reset_lat: got %0d want 6", b_lat); else n_pass++;
      drive_b(1'b1, 1'b0, 1'b0, 1'b1);
      drive_b(1'b0, 1'b0, 1'b0, 1'b1);
      drive_b(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_tmo !== 1'b0) $display("FAIL mid_reset_flags: got busy=%0b valid=%0b tmo=%0b want 0 0 0", b_busy, b_valid, b_tmo); else n_pass++;
      n_checks++; if (b_lat !== 4'd0 || b_n !== 4'd0) $display("FAIL mid_reset_regs: got lat=%0d n=%0d want 0 0", b_lat, b_n); else n_pass++;
`ifdef LATENCY_METER_MINMAX_EN
      n_checks++; if (b_min !== 4'hf || b_max !== 4'd0) $display("FAIL mid_reset_minmax: got %0d/%0d want 15/0", b_min, b_max); else n_pass++;
`endif
      for (int j = 0; j < 6; j++) begin
         drive_b(1'b0, (j == 2), 1'b0, 1'b1);
         if (b_valid === 1'b1 || b_busy === 1'b1) nvalid++;
      end
      n_checks++; if (nvalid != 0) $display("FAIL mid_reset_aborted: got %0d active cycles want 0", nvalid); else n_pass++;
   endtask

   initial begin
      start = 1'b0; stop = 1'b0; clear = 1'b0; rst_n = 1'b0;
      b_start = 1'b0; b_stop = 1'b0; b_clear = 1'b0; b_rst_n = 1'b0;
      test_reset();
      test_zero();
      test_chain();
      test_timeout();
      test_back_to_back();
      test_clear();
      test_random();
      test_saturation();
`ifdef LATENCY_METER_MINMAX_EN
      test_minmax();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
